// File: rtl/onehot_decoder_pipe_if.sv
// Handshake bundle for onehot_decoder_pipe: producer index in, one-hot vector out, flush, sticky.
// Latency: none (wires only).
// Backpressure: carries in_ready toward the producer and out_ready toward the decoder.
//
// Signals:
//   in_valid/in_idx/in_ready      producer side, valid/ready on a binary index
//   out_valid/out_onehot/out_err  head entry of the buffer, decoded
//   out_ready                     consumer accepts the head entry
//   flush                         synchronous clear of buffer and sticky vector
//   sticky                        OR of every vector delivered since reset/flush
interface onehot_decoder_pipe_if #(
  parameter int WIDTH = 16,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
);
  logic             in_valid;
  logic [IDX_W-1:0] in_idx;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_onehot;
  logic             out_err;
  logic             out_ready;
  logic             flush;
  logic [WIDTH-1:0] sticky;

  // master drives the decoder (producer, consumer and flush control together)
  modport master (
    output in_valid, in_idx, out_ready, flush,
    input  in_ready, out_valid, out_onehot, out_err, sticky
  );

  // slave is the decoder itself
  modport slave (
    input  in_valid, in_idx, out_ready, flush,
    output in_ready, out_valid, out_onehot, out_err, sticky
  );
endinterface

// File: rtl/onehot_decoder_pipe.sv
// Binary index -> one-hot decoder behind a 2-entry FIFO, plus sticky OR of delivered vectors.
// Latency: 1 cycle push-to-output; 0 cycles when empty if DECODER_BYPASS_EN is defined.
// Backpressure: in_ready = not full & ~flush & ~reset; never depends on out_ready.
//
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high
//   bus    onehot_decoder_pipe_if.slave (in_valid/in_idx/in_ready, out_valid/out_onehot/
//          out_err/out_ready, flush, sticky)
// Optional macro: DECODER_BYPASS_EN -- when the buffer is empty the input is decoded and
//          presented in the same cycle; if the consumer takes it, it is never written.
module onehot_decoder_pipe #(
  parameter int WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  onehot_decoder_pipe_if.slave  bus
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [IDX_W-1:0] mem_q [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q,  count_d;
  logic [WIDTH-1:0] sticky_q, sticky_d;

  logic             push, pop;
  logic             wr_en, rd_en;
  logic             head_vld;
  logic [IDX_W-1:0] head_idx;
  logic             head_in_range;
  logic [WIDTH-1:0] head_oh;

  // WIDTH <= 2**IDX_W, so every i < WIDTH is exactly representable in IDX_W bits.
  function automatic logic [WIDTH-1:0] decode(input logic [IDX_W-1:0] idx);
    logic [WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < WIDTH; i++) begin
      v[i] = (idx == IDX_W'(i));
    end
    return v;
  endfunction

  assign bus.in_ready = (count_q != 2'd2) & ~bus.flush & ~reset;
  assign push         = bus.in_valid & bus.in_ready;
  assign pop          = head_vld & bus.out_ready;

`ifdef DECODER_BYPASS_EN
  logic byp;

  // Empty buffer: present the incoming index directly. A bypassed entry that the
  // consumer takes this cycle is neither written nor read from storage.
  assign byp      = (count_q == 2'd0) & bus.in_valid & ~bus.flush & ~reset;
  assign head_vld = ((count_q != 2'd0) | byp) & ~reset;
  assign head_idx = byp ? bus.in_idx : mem_q[rd_ptr_q];
  assign wr_en    = push & ~(byp & bus.out_ready);
  assign rd_en    = pop & ~byp;
`else
  assign head_vld = (count_q != 2'd0) & ~reset;
  assign head_idx = mem_q[rd_ptr_q];
  assign wr_en    = push;
  assign rd_en    = pop;
`endif

  // Index widened by one bit so the compare against WIDTH cannot overflow.
  assign head_in_range = ({1'b0, head_idx} < (IDX_W + 1)'(WIDTH));
  assign head_oh       = (head_vld & head_in_range) ? decode(head_idx) : '0;

  assign bus.out_valid  = head_vld;
  assign bus.out_onehot = head_oh;
  assign bus.out_err    = head_vld & ~head_in_range;
  // Masked during reset so the first reset cycle already shows a cleared vector.
  assign bus.sticky     = reset ? '0 : sticky_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    sticky_d = sticky_q;

    // 1-bit pointers: toggling is the 1 -> 0 wrap.
    if (wr_en) wr_ptr_d = ~wr_ptr_q;
    if (rd_en) rd_ptr_d = ~rd_ptr_q;

    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    // Out-of-range heads decode to zero, so they leave sticky untouched.
    if (pop) sticky_d = sticky_q | head_oh;

    // Flush wins over a same-cycle pop: the consumer still sees the entry,
    // but it is not accumulated.
    if (bus.flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
      sticky_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      sticky_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
    end
  end

  // Payload storage needs no reset: it is only observed while count_q says it is live.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= bus.in_idx;
  end

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// Directed bench for onehot_decoder_pipe: WIDTH=16 instance driven from a vector table,
// WIDTH=12 instance driven by a short hand sequence for the out-of-range case.
module tb_onehot_decoder_pipe;

  logic clock;
  logic reset;

  onehot_decoder_pipe_if #(.WIDTH(16)) bus16 ();
  onehot_decoder_pipe_if #(.WIDTH(12)) bus12 ();

  onehot_decoder_pipe #(.WIDTH(16)) u_dut16 (
    .clock (clock),
    .reset (reset),
    .bus   (bus16)
  );

  onehot_decoder_pipe #(.WIDTH(12)) u_dut12 (
    .clock (clock),
    .reset (reset),
    .bus   (bus12)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  // One row = inputs held for one cycle, and the outputs expected before that cycle's edge.
  typedef struct {
    string       name;
    logic        rst;
    logic        fl;
    logic        vld;
    logic [3:0]  idx;
    logic        ordy;
    logic        e_irdy;
    logic        e_ovld;
    logic [15:0] e_oh;
    logic        e_err;
    logic [15:0] e_st;
  } vec_t;

  function automatic vec_t mk(input string n, input logic r, input logic f, input logic v,
                              input logic [3:0] i, input logic o, input logic ei,
                              input logic eo, input logic [15:0] eoh, input logic ee,
                              input logic [15:0] es);
    vec_t t;
    t.name = n;  t.rst = r;  t.fl = f;  t.vld = v;  t.idx = i;  t.ordy = o;
    t.e_irdy = ei;  t.e_ovld = eo;  t.e_oh = eoh;  t.e_err = ee;  t.e_st = es;
    return t;
  endfunction

  vec_t tbl[$];

  initial begin
    reset           = 1'b1;
    bus16.in_valid  = 1'b0;
    bus16.in_idx    = '0;
    bus16.out_ready = 1'b0;
    bus16.flush     = 1'b0;
    bus12.in_valid  = 1'b0;
    bus12.in_idx    = '0;
    bus12.out_ready = 1'b0;
    bus12.flush     = 1'b0;

    //                 name          rst fl vld idx  ordy irdy ovld oh        err sticky
    tbl.push_back(mk("rst0",         1, 0, 0, 4'd0, 0,   0,   0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk("rst1",         1, 0, 1, 4'd5, 1,   0,   0, 16'h0000, 0, 16'h0000));
    // single entry, 1-cycle latency
    tbl.push_back(mk("t1_push5",     0, 0, 1, 4'd5, 1,   1,   0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk("t1_out5",      0, 0, 0, 4'd0, 1,   1,   1, 16'h0020, 0, 16'h0000));
    tbl.push_back(mk("t1_idle",      0, 0, 0, 4'd0, 0,   1,   0, 16'h0000, 0, 16'h0020));
    // fill to 2 under backpressure, third push refused, drain in order
    tbl.push_back(mk("t2_push3",     0, 0, 1, 4'd3, 0,   1,   0, 16'h0000, 0, 16'h0020));
    tbl.push_back(mk("t2_push7",     0, 0, 1, 4'd7, 0,   1,   1, 16'h0008, 0, 16'h0020));
    tbl.push_back(mk("t2_push9",     0, 0, 1, 4'd9, 0,   0,   1, 16'h0008, 0, 16'h0020));
    tbl.push_back(mk("t2_pop3",      0, 0, 0, 4'd0, 1,   0,   1, 16'h0008, 0, 16'h0020));
    tbl.push_back(mk("t2_pop7",      0, 0, 0, 4'd0, 1,   1,   1, 16'h0080, 0, 16'h0028));
    tbl.push_back(mk("t2_empty",     0, 0, 0, 4'd0, 0,   1,   0, 16'h0000, 0, 16'h00a8));
    tbl.push_back(mk("t2_flush",     0, 1, 0, 4'd0, 0,   0,   0, 16'h0000, 0, 16'h00a8));
    tbl.push_back(mk("t2_clr",       0, 0, 0, 4'd0, 0,   1,   0, 16'h0000, 0, 16'h0000));
    // streaming 0..15: output k-1 visible while k is pushed
    for (int k = 0; k < 16; k++) begin
      tbl.push_back(mk($sformatf("t3_k%0d", k), 0, 0, 1, 4'(k), 1, 1,
                       (k > 0),
                       (k > 0) ? 16'(1 << (k - 1)) : 16'h0000,
                       0,
                       (k > 0) ? 16'((1 << (k - 1)) - 1) : 16'h0000));
    end
    tbl.push_back(mk("t3_tail",      0, 0, 0, 4'd0, 1,   1,   1, 16'h8000, 0, 16'h7fff));
    tbl.push_back(mk("t3_done",      0, 0, 0, 4'd0, 0,   1,   0, 16'h0000, 0, 16'hffff));
    // full buffer {2,4}, sticky=0001, flush with push(6)+pop in the same cycle
    tbl.push_back(mk("t5_flush0",    0, 1, 0, 4'd0, 0,   0,   0, 16'h0000, 0, 16'hffff));
    tbl.push_back(mk("t5_push0",     0, 0, 1, 4'd0, 1,   1,   0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk("t5_push2",     0, 0, 1, 4'd2, 1,   1,   1, 16'h0001, 0, 16'h0000));
    tbl.push_back(mk("t5_push4",     0, 0, 1, 4'd4, 0,   1,   1, 16'h0004, 0, 16'h0001));
    tbl.push_back(mk("t5_fl",        0, 1, 1, 4'd6, 1,   0,   1, 16'h0004, 0, 16'h0001));
    tbl.push_back(mk("t5_after",     0, 0, 0, 4'd0, 1,   1,   0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk("t5_after2",    0, 0, 0, 4'd0, 1,   1,   0, 16'h0000, 0, 16'h0000));
    // reset while holding two entries
    tbl.push_back(mk("t6_push1",     0, 0, 1, 4'd1, 0,   1,   0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk("t6_push2",     0, 0, 1, 4'd2, 0,   1,   1, 16'h0002, 0, 16'h0000));
    tbl.push_back(mk("t6_rst",       1, 0, 0, 4'd0, 1,   0,   0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk("t6_post",      0, 0, 0, 4'd0, 1,   1,   0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk("t6_push9",     0, 0, 1, 4'd9, 1,   1,   0, 16'h0000, 0, 16'h0000));
    tbl.push_back(mk("t6_out9",      0, 0, 0, 4'd0, 1,   1,   1, 16'h0200, 0, 16'h0000));
    tbl.push_back(mk("t6_end",       0, 0, 0, 4'd0, 0,   1,   0, 16'h0000, 0, 16'h0200));

    #1;
    foreach (tbl[n]) begin
      reset           = tbl[n].rst;
      bus16.flush     = tbl[n].fl;
      bus16.in_valid  = tbl[n].vld;
      bus16.in_idx    = tbl[n].idx;
      bus16.out_ready = tbl[n].ordy;
      #1;
      chk({tbl[n].name, ".in_ready"},   32'(bus16.in_ready),   32'(tbl[n].e_irdy));
      chk({tbl[n].name, ".out_valid"},  32'(bus16.out_valid),  32'(tbl[n].e_ovld));
      chk({tbl[n].name, ".out_onehot"}, 32'(bus16.out_onehot), 32'(tbl[n].e_oh));
      chk({tbl[n].name, ".out_err"},    32'(bus16.out_err),    32'(tbl[n].e_err));
      chk({tbl[n].name, ".sticky"},     32'(bus16.sticky),     32'(tbl[n].e_st));
      @(posedge clock);
      #1;
    end
    bus16.in_valid  = 1'b0;
    bus16.out_ready = 1'b0;

    // WIDTH=12: last legal index, then an out-of-range one that must not touch sticky.
    bus12.in_valid  = 1'b1;
    bus12.in_idx    = 4'd11;
    bus12.out_ready = 1'b1;
    #1;
    chk("w12_push11.in_ready",  32'(bus12.in_ready),  32'd1);
    chk("w12_push11.out_valid", 32'(bus12.out_valid), 32'd0);
    @(posedge clock); #1;

    bus12.in_idx = 4'd13;
    #1;
    chk("w12_out11.out_valid",  32'(bus12.out_valid),  32'd1);
    chk("w12_out11.out_onehot", 32'(bus12.out_onehot), 32'h800);
    chk("w12_out11.out_err",    32'(bus12.out_err),    32'd0);
    @(posedge clock); #1;

    bus12.in_valid = 1'b0;
    #1;
    chk("w12_out13.out_valid",  32'(bus12.out_valid),  32'd1);
    chk("w12_out13.out_onehot", 32'(bus12.out_onehot), 32'h000);
    chk("w12_out13.out_err",    32'(bus12.out_err),    32'd1);
    chk("w12_out13.sticky",     32'(bus12.sticky),     32'h800);
    @(posedge clock); #1;

    bus12.out_ready = 1'b0;
    #1;
    chk("w12_end.out_valid", 32'(bus12.out_valid), 32'd0);
    chk("w12_end.out_err",   32'(bus12.out_err),   32'd0);
    chk("w12_end.sticky",    32'(bus12.sticky),    32'h800);
    @(posedge clock); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
